// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch target and EX/MEM register.
// Optional iterative shift-add multiplier with front-end stall, built when MULT_UNIT_EN is defined.
module ex_stage #(
  parameter  int MUL_CYCLES = 32,
  localparam int DATA_W     = MUL_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        control_WB_s3,
  input  logic [1:0]        control_MEM_s3,
  input  logic [3:0]        control_EX_s3,
  input  logic [DATA_W-1:0] pc_s3,
  input  logic [DATA_W-1:0] rs_data_s3,
  input  logic [DATA_W-1:0] rt_data_s3,
  input  logic [DATA_W-1:0] seimm_s3,
  input  logic [4:0]        rt_addr_s3,
  input  logic [4:0]        rd_addr_s3,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [DATA_W-1:0] mem_wb_wdata,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic [1:0]        control_WB_s4,
  output logic [1:0]        control_MEM_s4,
  output logic [DATA_W-1:0] alu_result_s4,
  output logic [DATA_W-1:0] store_data_s4,
  output logic [4:0]        wr_addr_s4,
  output logic              zero_s4,
  output logic [DATA_W-1:0] branch_target_s4
);

  logic              w_reg_dst;
  logic [1:0]        w_alu_op;
  logic              w_alu_src;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic              w_stall;

  assign w_reg_dst = control_EX_s3[3];
  assign w_alu_op  = control_EX_s3[2:1];
  assign w_alu_src = control_EX_s3[0];

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic [DATA_W-1:0] wb_val,
                                                input logic [DATA_W-1:0] mem_val);
    case (sel)
      2'b01:   fwd_mux = wb_val;
      2'b10:   fwd_mux = mem_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

  // funct 18 yields 0 here; the multiplier product is substituted on completion.
  function automatic logic [DATA_W-1:0] alu_op(input logic [1:0] op,
                                               input logic [5:0] funct,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      2'b00: alu_op = a + b;
      2'b01: alu_op = a - b;
      2'b10: begin
        case (funct)
          6'h20:   alu_op = a + b;
          6'h22:   alu_op = a - b;
          6'h24:   alu_op = a & b;
          6'h25:   alu_op = a | b;
          6'h2A:   alu_op = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default: alu_op = '0;
        endcase
      end
      default: alu_op = '0;
    endcase
  endfunction

  always_comb begin
    w_op_a  = fwd_mux(fwd_a_sel, rs_data_s3, mem_wb_wdata, ex_mem_result);
    w_fwd_b = fwd_mux(fwd_b_sel, rt_data_s3, mem_wb_wdata, ex_mem_result);
    w_op_b  = w_alu_src ? seimm_s3 : w_fwd_b;
    w_alu   = alu_op(w_alu_op, seimm_s3[5:0], w_op_a, w_op_b);
  end

`ifdef MULT_UNIT_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_is_mul;
  logic              w_start;
  logic              w_step;
  logic              w_load_prod;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  assign w_is_mul = (w_alu_op == 2'b10) && (seimm_s3[5:0] == 6'h18);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ex_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_is_mul) w_next = S_BUSY;
        S_BUSY:  if (r_cnt == CNT_W'(MUL_CYCLES - 1)) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Flush overrides every FSM action, including the stall request.
  always_comb begin
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_load_prod = 1'b0;
    if (!ex_flush) begin
      case (r_state)
        S_IDLE: begin
          w_stall = w_is_mul;
          w_start = w_is_mul;
        end
        S_BUSY: begin
          w_stall = 1'b1;
          w_step  = 1'b1;
        end
        S_DONE:  w_load_prod = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_mul_a <= w_op_a;
      r_mul_b <= w_op_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_acc   <= r_acc + (r_mul_b[0] ? r_mul_a : '0);
      r_mul_a <= r_mul_a << 1;
      r_mul_b <= r_mul_b >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_result = w_load_prod ? r_acc : w_alu;
  assign ex_stall = w_stall & rst_n;
`else
  assign w_stall  = 1'b0;
  assign w_result = w_alu;
  assign ex_stall = 1'b0;
`endif

  // EX/MEM boundary: controls bubble on stall or flush, data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_WB_s4    <= '0;
      control_MEM_s4   <= '0;
      alu_result_s4    <= '0;
      store_data_s4    <= '0;
      wr_addr_s4       <= '0;
      zero_s4          <= 1'b0;
      branch_target_s4 <= '0;
    end else begin
      if (ex_flush || w_stall) begin
        control_WB_s4  <= '0;
        control_MEM_s4 <= '0;
      end else begin
        control_WB_s4  <= control_WB_s3;
        control_MEM_s4 <= control_MEM_s3;
      end
      if (!w_stall) begin
        alu_result_s4    <= w_result;
        store_data_s4    <= w_fwd_b;
        wr_addr_s4       <= w_reg_dst ? rd_addr_s3 : rt_addr_s3;
        zero_s4          <= (w_result == '0);
        branch_target_s4 <= pc_s3 + (seimm_s3 << 2);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized single-cycle ops
// against a behavioural model; multiplier cases depend on MULT_UNIT_EN.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  control_WB_s3, control_MEM_s3;
  logic [3:0]  control_EX_s3;
  logic [31:0] pc_s3, rs_data_s3, rt_data_s3, seimm_s3;
  logic [4:0]  rt_addr_s3, rd_addr_s3;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] ex_mem_result, mem_wb_wdata;
  logic        ex_flush;
  logic        ex_stall;
  logic [1:0]  control_WB_s4, control_MEM_s4;
  logic [31:0] alu_result_s4, store_data_s4, branch_target_s4;
  logic [4:0]  wr_addr_s4;
  logic        zero_s4;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .control_WB_s3(control_WB_s3), .control_MEM_s3(control_MEM_s3),
    .control_EX_s3(control_EX_s3), .pc_s3(pc_s3),
    .rs_data_s3(rs_data_s3), .rt_data_s3(rt_data_s3), .seimm_s3(seimm_s3),
    .rt_addr_s3(rt_addr_s3), .rd_addr_s3(rd_addr_s3),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_mem_result(ex_mem_result), .mem_wb_wdata(mem_wb_wdata),
    .ex_flush(ex_flush), .ex_stall(ex_stall),
    .control_WB_s4(control_WB_s4), .control_MEM_s4(control_MEM_s4),
    .alu_result_s4(alu_result_s4), .store_data_s4(store_data_s4),
    .wr_addr_s4(wr_addr_s4), .zero_s4(zero_s4),
    .branch_target_s4(branch_target_s4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ex, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic fl);
    control_EX_s3 = ex;
    rs_data_s3    = rs;
    rt_data_s3    = rt;
    seimm_s3      = imm;
    fwd_a_sel     = fa;
    fwd_b_sel     = fb;
    ex_flush      = fl;
  endtask

  function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'd1)      return mem_wb_wdata;
    else if (sel == 2'd2) return ex_mem_result;
    else                  return reg_v;
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] a, b;
    a = fwd_val(fwd_a_sel, rs_data_s3);
    b = control_EX_s3[0] ? seimm_s3 : fwd_val(fwd_b_sel, rt_data_s3);
    case (control_EX_s3[2:1])
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        if (seimm_s3[5:0] == 6'h20) return a + b;
        if (seimm_s3[5:0] == 6'h22) return a - b;
        if (seimm_s3[5:0] == 6'h24) return a & b;
        if (seimm_s3[5:0] == 6'h25) return a | b;
        if (seimm_s3[5:0] == 6'h2A) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Call after the capturing edge while the inputs are still applied.
  task automatic check_all(input string tag);
    logic [31:0] r;
    r = ref_result();
    chk({tag, ".res"}, alu_result_s4, r);
    chk({tag, ".zero"}, zero_s4, (r == 32'd0));
    chk({tag, ".ctl"}, {control_WB_s4, control_MEM_s4},
        ex_flush ? 4'd0 : {control_WB_s3, control_MEM_s3});
    chk({tag, ".st"}, store_data_s4, fwd_val(fwd_b_sel, rt_data_s3));
    chk({tag, ".wa"}, wr_addr_s4, control_EX_s3[3] ? rd_addr_s3 : rt_addr_s3);
    chk({tag, ".bt"}, branch_target_s4, pc_s3 + seimm_s3 * 4);
  endtask

  task automatic single(input string tag);
    #1 chk({tag, ".stall"}, ex_stall, 1'b0);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    control_WB_s3 = 2'b10; control_MEM_s3 = 2'b01;
    pc_s3 = 32'h0; rt_addr_s3 = 5'd3; rd_addr_s3 = 5'd9;
    ex_mem_result = 32'h0; mem_wb_wdata = 32'h0;
    drive(4'b1100, 32'd0, 32'd0, 32'h20, 2'd0, 2'd0, 1'b0);

    #3;
    chk("rst.res", alu_result_s4, 32'd0);
    chk("rst.ctl", {control_WB_s4, control_MEM_s4}, 4'd0);
    chk("rst.bt", branch_target_s4, 32'd0);
    chk("rst.stall", ex_stall, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    drive(4'b1100, 32'd5, 32'd7, 32'h20, 2'd0, 2'd0, 1'b0);
    single("add");
    chk("add.12", alu_result_s4, 32'd12);
    chk("add.z", zero_s4, 1'b0);

    pc_s3 = 32'h100;
    drive(4'b0010, 32'd9, 32'd9, 32'd3, 2'd0, 2'd0, 1'b0);
    single("sub");
    chk("sub.0", alu_result_s4, 32'd0);
    chk("sub.z", zero_s4, 1'b1);
    chk("sub.bt", branch_target_s4, 32'h10C);

    drive(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'h2A, 2'd0, 2'd0, 1'b0);
    single("slt");
    chk("slt.1", alu_result_s4, 32'd1);

    ex_mem_result = 32'd4;
    drive(4'b1100, 32'd100, 32'd4, 32'h20, 2'd2, 2'd0, 1'b0);
    single("fwd");
    chk("fwd.8", alu_result_s4, 32'd8);

`ifdef MULT_UNIT_EN
    begin
      int n, bad;
      logic [31:0] held;
      control_WB_s3 = 2'b11; control_MEM_s3 = 2'b11;
      drive(4'b1100, 32'h0001_0000, 32'h0003_0003, 32'h18, 2'd0, 2'd0, 1'b0);
      held = alu_result_s4;
      #1 chk("mul.stall0", ex_stall, 1'b1);
      n = 0; bad = 0;
      while (ex_stall === 1'b1 && n < 100) begin
        n++;
        @(posedge clk); #1;
        if ({control_WB_s4, control_MEM_s4} !== 4'd0 || alu_result_s4 !== held) bad++;
      end
      chk("mul.stall_cycles", n, 33);
      chk("mul.bubble_hold", bad, 0);
      @(posedge clk); #1;
      chk("mul.res", alu_result_s4, 32'h0003_0000);
      chk("mul.ctl", {control_WB_s4, control_MEM_s4}, 4'hF);
      chk("mul.wa", wr_addr_s4, rd_addr_s3);
      control_WB_s3 = 2'b10; control_MEM_s3 = 2'b01;

      // Random mul back-to-back after a completed one
      drive(4'b1100, $urandom, $urandom, 32'h18, 2'd0, 2'd0, 1'b0);
      n = 0;
      #1;
      while (ex_stall === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
      chk("mul2.stall_cycles", n, 33);
      @(posedge clk); #1;
      chk("mul2.res", alu_result_s4, rs_data_s3 * rt_data_s3);

      drive(4'b1100, 32'd6, 32'd7, 32'h18, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
      ex_flush = 1'b1;
      #1 chk("flush.stall", ex_stall, 1'b0);
      @(posedge clk); #1;
      chk("flush.ctl", {control_WB_s4, control_MEM_s4}, 4'd0);
      drive(4'b1100, 32'd20, 32'd22, 32'h20, 2'd0, 2'd0, 1'b0);
      single("flush.add");
      chk("flush.add42", alu_result_s4, 32'd42);

      drive(4'b1100, 32'd3, 32'd3, 32'h18, 2'd0, 2'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("rstmul.stall", ex_stall, 1'b0);
      chk("rstmul.res", alu_result_s4, 32'd0);
      chk("rstmul.ctl", {control_WB_s4, control_MEM_s4}, 4'd0);
      chk("rstmul.st", store_data_s4, 32'd0);
      chk("rstmul.bt", branch_target_s4, 32'd0);
      drive(4'b1100, 32'd1, 32'd2, 32'h20, 2'd0, 2'd0, 1'b0);
      #1 rst_n = 1'b1;
      single("rstmul.add");
    end
`else
    drive(4'b1100, 32'h0001_0000, 32'h0003_0003, 32'h18, 2'd0, 2'd0, 1'b0);
    single("nomul");
    chk("nomul.res0", alu_result_s4, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst2.res", alu_result_s4, 32'd0);
    chk("rst2.stall", ex_stall, 1'b0);
    drive(4'b1100, 32'd1, 32'd2, 32'h20, 2'd0, 2'd0, 1'b0);
    #1 rst_n = 1'b1;
    single("rst2.add");
`endif

    for (int k = 0; k < 300; k++) begin
      logic [31:0] imm;
      logic [5:0]  functs [7];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h3F};
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[5:0] = functs[$urandom_range(0, 6)];
      drive(4'($urandom), $urandom, $urandom, imm, 2'($urandom), 2'($urandom),
            ($urandom_range(0, 9) == 0));
`ifdef MULT_UNIT_EN
      if (control_EX_s3[2:1] == 2'd2 && seimm_s3[5:0] == 6'h18) seimm_s3[5:0] = 6'h20;
`endif
      if ($urandom_range(0, 3) == 0) rs_data_s3 = rt_data_s3;
      control_WB_s3  = 2'($urandom);
      control_MEM_s3 = 2'($urandom);
      pc_s3          = $urandom;
      rt_addr_s3     = 5'($urandom);
      rd_addr_s3     = 5'($urandom);
      ex_mem_result  = $urandom;
      mem_wb_wdata   = $urandom;
      single($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
